// File: rtl/sid_pkg.sv
// SID register map, routing/mode bit positions and mixer sequencing states.
// Shared by the filter mixer and its bench.
package sid_pkg;

   localparam logic [4:0] ADDR_FILT = 5'h17;
   localparam logic [4:0] ADDR_MODE = 5'h18;

   localparam int FILT_V0  = 0;
   localparam int FILT_V1  = 1;
   localparam int FILT_V2  = 2;
   localparam int FILT_EXT = 3;

   localparam int MODE_LP   = 0;
   localparam int MODE_BP   = 1;
   localparam int MODE_HP   = 2;
   localparam int MODE_3OFF = 3;

   typedef enum logic [2:0] {
      IDLE,
      ACC0,
      ACC1,
      ACC2,
      ACCX,
      FMIX,
      VOL
   } state_t;

endpackage

// File: rtl/filter_mixer_if.sv
// SID register write bus shared by the voice, filter and mixer blocks.
interface filter_mixer_if;

   logic       WR;
   logic [4:0] ADDR;
   logic [7:0] DATA;

   modport master (output WR, ADDR, DATA);
   modport slave  (input  WR, ADDR, DATA);

endinterface

// File: rtl/filter_mixer_sat16.sv
// Signed clamp of an IN_W-bit value into the 16-bit sample range.
module sat16 #(
   parameter int IN_W = 19
) (
   input  logic signed [IN_W-1:0] in_i,
   output logic signed [15:0]     out_o
);

   localparam logic signed [IN_W-1:0] MAXV = IN_W'(32'sd32767);
   localparam logic signed [IN_W-1:0] MINV = IN_W'(-32'sd32768);

   always_comb begin
      out_o = in_i[15:0];
      if (in_i > MAXV)
         out_o = 16'sh7FFF;
      else if (in_i < MINV)
         out_o = 16'sh8000;
   end

endmodule

// File: rtl/filter_mixer.sv
// SID filter mixer: routes voices into the filter and mixes the
// direct path with the selected filter outputs under master volume.
module filter_mixer
   import sid_pkg::*;
#(
   parameter int ACC_W     = 19,
   parameter int VOL_SHIFT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clkEn,
   input  logic signed [15:0] iVoice0,
   input  logic signed [15:0] iVoice1,
   input  logic signed [15:0] iVoice2,
   input  logic signed [15:0] iExt,
   input  logic signed [15:0] iLP,
   input  logic signed [15:0] iBP,
   input  logic signed [15:0] iHP,
   filter_mixer_if.slave      bus,
   output logic signed [15:0] oFiltIn,
   output logic signed [15:0] oOut,
   output logic               oValid
);

   logic [3:0] filt_q, mode_q, vol_q;
   logic [3:0] wfilt_q, wmode_q, wvol_q;
   logic signed [15:0] v0_q, v1_q, v2_q, ext_q;
   logic signed [15:0] lp_q, bp_q, hp_q;
   logic signed [ACC_W-1:0] accd_q, accd_d;
   logic signed [ACC_W-1:0] accf_q, accf_d;
   logic signed [15:0] fi_q, fi_d, out_q, out_d;
   logic signed [15:0] fsat, vsat;
   logic signed [ACC_W-1:0] mix;
   logic signed [23:0] prod, scaled;
   logic valid_q, valid_d;
   state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= '0;
         mode_q <= '0;
         vol_q  <= '0;
      end else if (bus.WR) begin
         if (bus.ADDR == ADDR_FILT) begin
            filt_q <= bus.DATA[3:0];
         end else if (bus.ADDR == ADDR_MODE) begin
            vol_q  <= bus.DATA[3:0];
            mode_q <= bus.DATA[7:4];
         end
      end
   end

   // Working copy so later register writes leave the sample in flight alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q    <= '0;
         v1_q    <= '0;
         v2_q    <= '0;
         ext_q   <= '0;
         lp_q    <= '0;
         bp_q    <= '0;
         hp_q    <= '0;
         wfilt_q <= '0;
         wmode_q <= '0;
         wvol_q  <= '0;
      end else if (clkEn) begin
         v0_q    <= iVoice0;
         v1_q    <= iVoice1;
         v2_q    <= iVoice2;
         ext_q   <= iExt;
         lp_q    <= iLP;
         bp_q    <= iBP;
         hp_q    <= iHP;
         wfilt_q <= filt_q;
         wmode_q <= mode_q;
         wvol_q  <= vol_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         accd_q  <= '0;
         accf_q  <= '0;
         fi_q    <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         accd_q  <= accd_d;
         accf_q  <= accf_d;
         fi_q    <= fi_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      mix = accd_q;
      if (wmode_q[MODE_LP]) mix = mix + ACC_W'(lp_q);
      if (wmode_q[MODE_BP]) mix = mix + ACC_W'(bp_q);
      if (wmode_q[MODE_HP]) mix = mix + ACC_W'(hp_q);
      prod   = 24'(accd_q) * $signed({20'b0, wvol_q});
      scaled = prod >>> VOL_SHIFT;
   end

   sat16 #(.IN_W(ACC_W)) u_fsat (.in_i(accf_q), .out_o(fsat));
   sat16 #(.IN_W(24))    u_vsat (.in_i(scaled), .out_o(vsat));

   always_comb begin
      state_d = state_q;
      accd_d  = accd_q;
      accf_d  = accf_q;
      fi_d    = fi_q;
      out_d   = out_q;
      valid_d = 1'b0;
      if (clkEn) begin
         state_d = ACC0;
         accd_d  = '0;
         accf_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ACC0: begin
               if (wfilt_q[FILT_V0]) accf_d = accf_q + ACC_W'(v0_q);
               else                  accd_d = accd_q + ACC_W'(v0_q);
               state_d = ACC1;
            end
            ACC1: begin
               if (wfilt_q[FILT_V1]) accf_d = accf_q + ACC_W'(v1_q);
               else                  accd_d = accd_q + ACC_W'(v1_q);
               state_d = ACC2;
            end
            ACC2: begin
               if (wfilt_q[FILT_V2])
                  accf_d = accf_q + ACC_W'(v2_q);
               else if (!wmode_q[MODE_3OFF])
                  accd_d = accd_q + ACC_W'(v2_q);
               state_d = ACCX;
            end
            ACCX: begin
               if (wfilt_q[FILT_EXT]) accf_d = accf_q + ACC_W'(ext_q);
               else                   accd_d = accd_q + ACC_W'(ext_q);
               state_d = FMIX;
            end
            FMIX: begin
               fi_d    = fsat;
               accd_d  = mix;
               state_d = VOL;
            end
            VOL: begin
               out_d   = vsat;
               valid_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign oFiltIn = fi_q;
   assign oOut    = out_q;
   assign oValid  = valid_q;

endmodule

// File: tb/tb_filter_mixer.sv
// Scoreboard bench for filter_mixer: routing, modes, volume,
// saturation, restart on clkEn, write/snapshot ordering and reset.
module tb_filter_mixer;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic clkEn = 1'b0;
   logic signed [15:0] v0 = '0, v1 = '0, v2 = '0, ext = '0;
   logic signed [15:0] lp = '0, bp = '0, hp = '0;
   logic signed [15:0] oFiltIn, oOut;
   logic oValid;

   filter_mixer_if bus();

   filter_mixer dut (
      .clk(clk), .rst_n(rst_n), .clkEn(clkEn),
      .iVoice0(v0), .iVoice1(v1), .iVoice2(v2), .iExt(ext),
      .iLP(lp), .iBP(bp), .iHP(hp),
      .bus(bus),
      .oFiltIn(oFiltIn), .oOut(oOut), .oValid(oValid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [3:0] m_filt = '0, m_mode = '0, m_vol = '0;

   function automatic int sat(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic logic [31:0] model(input int a0, a1, a2, ax,
                                          input int l, b, h);
      int d, f, o;
      d = 0;
      f = 0;
      if (m_filt[0]) f += a0; else d += a0;
      if (m_filt[1]) f += a1; else d += a1;
      if (m_filt[2]) f += a2; else if (!m_mode[3]) d += a2;
      if (m_filt[3]) f += ax; else d += ax;
      if (m_mode[0]) d += l;
      if (m_mode[1]) d += b;
      if (m_mode[2]) d += h;
      o = sat((d * int'(m_vol)) >>> 4);
      return {16'(o), 16'(sat(f))};
   endfunction

   task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.WR = 1'b1;
      bus.ADDR = a;
      bus.DATA = d;
      @(negedge clk);
      bus.WR = 1'b0;
      if (a == 5'h17) m_filt = d[3:0];
      else if (a == 5'h18) begin
         m_vol = d[3:0];
         m_mode = d[7:4];
      end
   endtask

   task automatic set_in(input int a0, a1, a2, ax, l, b, h);
      v0 = 16'(a0); v1 = 16'(a1); v2 = 16'(a2); ext = 16'(ax);
      lp = 16'(l); bp = 16'(b); hp = 16'(h);
   endtask

   task automatic start_sample(input int a0, a1, a2, ax, l, b, h);
      @(negedge clk);
      set_in(a0, a1, a2, ax, l, b, h);
      clkEn = 1'b1;
      exp_q.push_back(model(a0, a1, a2, ax, l, b, h));
      @(negedge clk);
      clkEn = 1'b0;
   endtask

   task automatic wait_result(input string name);
      logic [31:0] e;
      int n;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (oValid) begin
            n = i;
            break;
         end
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected 6", name, n);
      end
      if (n != 0) begin
         checks++;
         if (oOut !== e[31:16]) begin
            errors++;
            $display("FAIL %s oOut: got %0d expected %0d",
                     name, oOut, $signed(e[31:16]));
         end
         checks++;
         if (oFiltIn !== e[15:0]) begin
            errors++;
            $display("FAIL %s oFiltIn: got %0d expected %0d",
                     name, oFiltIn, $signed(e[15:0]));
         end
         @(posedge clk); #1;
         checks++;
         if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: oValid got %b expected 0", name, oValid);
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (oOut !== 16'sd0) begin
         errors++;
         $display("FAIL %s oOut: got %0d expected 0", name, oOut);
      end
      checks++;
      if (oFiltIn !== 16'sd0) begin
         errors++;
         $display("FAIL %s oFiltIn: got %0d expected 0", name, oFiltIn);
      end
      checks++;
      if (oValid !== 1'b0) begin
         errors++;
         $display("FAIL %s oValid: got %b expected 0", name, oValid);
      end
   endtask

   task automatic test_reset();
      bus.WR = 1'b0;
      bus.ADDR = '0;
      bus.DATA = '0;
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_direct();
      wr_reg(5'h18, 8'h0F);
      wr_reg(5'h17, 8'h00);
      start_sample(1000, 2000, 3000, 0, 0, 0, 0);
      wait_result("direct");
   endtask

   task automatic test_filter_route();
      wr_reg(5'h17, 8'h03);
      wr_reg(5'h18, 8'h1F);
      start_sample(1000, 2000, 3000, 0, -400, 0, 0);
      wait_result("route_lp");
   endtask

   task automatic test_3off();
      wr_reg(5'h17, 8'h00);
      wr_reg(5'h18, 8'h8F);
      start_sample(1000, 2000, 3000, 0, 0, 0, 0);
      wait_result("3off_drop");
      wr_reg(5'h17, 8'h04);
      start_sample(1000, 2000, 3000, 0, 0, 0, 0);
      wait_result("3off_routed");
   endtask

   task automatic test_saturation();
      wr_reg(5'h18, 8'h0F);
      wr_reg(5'h17, 8'h0F);
      start_sample(32767, 32767, 32767, 32767, 0, 0, 0);
      wait_result("sat_fi_pos");
      wr_reg(5'h17, 8'h00);
      wr_reg(5'h18, 8'h7F);
      start_sample(32767, 32767, 32767, 32767, 32767, 32767, 32767);
      wait_result("sat_out_pos");
      wr_reg(5'h17, 8'h0F);
      start_sample(-32768, -32768, -32768, -32768, -32768, -32768, -32768);
      wait_result("sat_fi_neg");
      wr_reg(5'h17, 8'h00);
      start_sample(-32768, -32768, -32768, -32768, -32768, -32768, -32768);
      wait_result("sat_out_neg");
   endtask

   task automatic test_back_to_back();
      int n, first;
      logic [31:0] e;
      wr_reg(5'h17, 8'h01);
      wr_reg(5'h18, 8'h0F);
      @(negedge clk);
      set_in(500, 600, 700, 0, 0, 0, 0);
      clkEn = 1'b1;
      @(negedge clk);
      clkEn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      set_in(-1200, 4000, 100, 50, 0, 0, 0);
      clkEn = 1'b1;
      e = model(-1200, 4000, 100, 50, 0, 0, 0);
      @(negedge clk);
      clkEn = 1'b0;
      n = 0;
      first = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (oValid) begin
            n++;
            if (first == 0) first = i;
            if (first == i) begin
               checks++;
               if (oOut !== e[31:16]) begin
                  errors++;
                  $display("FAIL restart oOut: got %0d expected %0d",
                           oOut, $signed(e[31:16]));
               end
               checks++;
               if (oFiltIn !== e[15:0]) begin
                  errors++;
                  $display("FAIL restart oFiltIn: got %0d expected %0d",
                           oFiltIn, $signed(e[15:0]));
               end
            end
         end
      end
      checks++;
      if (n != 1 || first != 6) begin
         errors++;
         $display("FAIL restart pulses: got %0d at %0d, expected 1 at 6",
                  n, first);
      end
   endtask

   task automatic test_wr_same_edge();
      wr_reg(5'h17, 8'h00);
      wr_reg(5'h18, 8'h0F);
      @(negedge clk);
      set_in(1000, 2000, 3000, 0, 0, 0, 0);
      clkEn = 1'b1;
      bus.WR = 1'b1;
      bus.ADDR = 5'h18;
      bus.DATA = 8'h08;
      exp_q.push_back(model(1000, 2000, 3000, 0, 0, 0, 0));
      @(negedge clk);
      clkEn = 1'b0;
      bus.WR = 1'b0;
      m_vol = 4'h8;
      m_mode = 4'h0;
      wait_result("wr_old_vol");
      start_sample(1000, 2000, 3000, 0, 0, 0, 0);
      wait_result("wr_new_vol");
   endtask

   task automatic test_reset_mid();
      wr_reg(5'h17, 8'h07);
      wr_reg(5'h18, 8'h1F);
      start_sample(1000, 2000, 3000, 0, 0, 0, 0);
      void'(exp_q.pop_back());
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      m_filt = '0;
      m_mode = '0;
      m_vol = '0;
      start_sample(1000, 2000, 3000, 0, 0, 0, 0);
      wait_result("post_reset_vol0");
   endtask

   task automatic test_random();
      logic [15:0] r[7];
      for (int k = 0; k < 8; k++) begin
         wr_reg(5'h17, 8'($urandom));
         wr_reg(5'h18, 8'($urandom));
         for (int j = 0; j < 7; j++) r[j] = 16'($urandom);
         start_sample(int'($signed(r[0])), int'($signed(r[1])),
                      int'($signed(r[2])), int'($signed(r[3])),
                      int'($signed(r[4])), int'($signed(r[5])),
                      int'($signed(r[6])));
         wait_result("random");
      end
   endtask

   initial begin
      test_reset();
      test_direct();
      test_filter_route();
      test_3off();
      test_saturation();
      test_back_to_back();
      test_wr_same_edge();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
